// File: rtl/izh_spike_decoder_if.sv
// Sample-stream and ISI-event bus between neuron/consumer (master) and spike decoder (slave).
// Combinational wiring only; evt_* follow valid/ready, sample side is strobed by ena.
interface izh_spike_decoder_if #(
  parameter int ISI_W = 16
);
  logic                    ena;
  logic signed [7:0]       v_in;
  logic                    evt_valid;
  logic                    evt_ready;
  logic [ISI_W-1:0]        evt_isi;
  logic                    evt_burst;

  modport master (
    output ena, v_in, evt_ready,
    input  evt_valid, evt_isi, evt_burst
  );

  modport slave (
    input  ena, v_in, evt_ready,
    output evt_valid, evt_isi, evt_burst
  );
endinterface

// File: rtl/izh_spike_decoder.sv
// Decodes membrane-voltage samples into spike pulses, counts, ISIs and burst runs; 1-cycle latency.
// One-entry ISI event register: a new event is dropped (sticky ovf) when full and evt_ready is low.
module izh_spike_decoder #(
  parameter logic signed [7:0] THRESH    = 8'sd64,
  parameter logic signed [7:0] REARM     = -8'sd32,
  parameter int                ISI_W     = 16,
  parameter int                CNT_W     = 16,
  parameter int                BURST_ISI = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  izh_spike_decoder_if.slave   bus,
  input  logic                 i_clr_cnt,
  output logic                 o_spike,
  output logic [CNT_W-1:0]     o_spike_count,
  output logic                 o_evt_ovf,
  output logic                 o_in_burst,
  output logic                 o_burst_done,
  output logic [7:0]           o_burst_len
);

  localparam logic [0:0]       ST_ARMED  = 1'b0;
  localparam logic [0:0]       ST_FIRED  = 1'b1;
  localparam logic [ISI_W-1:0] BURST_LIM = ISI_W'(BURST_ISI);

  logic [0:0]       r_state;
  logic [ISI_W-1:0] r_isi_cnt;
  logic             r_have_prev;
  logic [7:0]       r_run;
  logic             r_spike;
  logic [CNT_W-1:0] r_spike_count;
  logic             r_evt_valid;
  logic [ISI_W-1:0] r_evt_isi;
  logic             r_evt_burst;
  logic             r_evt_ovf;
  logic             r_in_burst;
  logic             r_burst_done;
  logic [7:0]       r_burst_len;

  logic             w_fire;
  logic             w_rearm;
  logic             w_isi_burst;
  logic             w_new_evt;
  logic             w_run_multi;
  logic             w_timeout;
  logic [7:0]       w_run_nxt;
  logic             w_bdone_nxt;

  assign w_fire      = bus.ena && (r_state == ST_ARMED) && (bus.v_in > THRESH);
  assign w_rearm     = bus.ena && (r_state == ST_FIRED) && (bus.v_in < REARM);
  assign w_isi_burst = (r_isi_cnt <= BURST_LIM);
  assign w_new_evt   = w_fire && r_have_prev;
  assign w_run_multi = (r_run >= 8'd2);
  // A run ends once the gap since the last spike exceeds the burst interval.
  assign w_timeout   = bus.ena && !w_fire && (r_isi_cnt == BURST_LIM) && w_run_multi;

  always_comb begin
    w_run_nxt   = r_run;
    w_bdone_nxt = 1'b0;
    if (w_fire) begin
      if (r_have_prev && w_isi_burst) begin
        w_run_nxt = (r_run == 8'hFF) ? r_run : r_run + 8'd1;
      end else begin
        w_bdone_nxt = w_run_multi;
        w_run_nxt   = 8'd1;
      end
    end else if (w_timeout) begin
      w_bdone_nxt = 1'b1;
      w_run_nxt   = 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_ARMED;
      r_isi_cnt     <= '0;
      r_have_prev   <= 1'b0;
      r_run         <= 8'd0;
      r_spike       <= 1'b0;
      r_spike_count <= '0;
      r_evt_valid   <= 1'b0;
      r_evt_isi     <= '0;
      r_evt_burst   <= 1'b0;
      r_evt_ovf     <= 1'b0;
      r_in_burst    <= 1'b0;
      r_burst_done  <= 1'b0;
      r_burst_len   <= 8'd0;
    end else begin
      r_spike      <= w_fire;
      r_run        <= w_run_nxt;
      r_in_burst   <= (w_run_nxt >= 8'd2);
      r_burst_done <= w_bdone_nxt;
      if (w_bdone_nxt) r_burst_len <= r_run;

      if (w_fire) begin
        r_state     <= ST_FIRED;
        r_have_prev <= 1'b1;
      end else if (w_rearm) begin
        r_state <= ST_ARMED;
      end

      if (bus.ena) begin
        if (w_fire)                r_isi_cnt <= {{(ISI_W-1){1'b0}}, 1'b1};
        else if (r_isi_cnt != '1)  r_isi_cnt <= r_isi_cnt + 1'b1;
      end

      if (w_new_evt && (!r_evt_valid || bus.evt_ready)) begin
        r_evt_valid <= 1'b1;
        r_evt_isi   <= r_isi_cnt;
        r_evt_burst <= w_isi_burst;
      end else if (r_evt_valid && bus.evt_ready) begin
        r_evt_valid <= 1'b0;
      end

      if (i_clr_cnt)                                          r_evt_ovf <= 1'b0;
      else if (w_new_evt && r_evt_valid && !bus.evt_ready)    r_evt_ovf <= 1'b1;

      if (i_clr_cnt)                           r_spike_count <= '0;
      else if (w_fire && r_spike_count != '1)  r_spike_count <= r_spike_count + 1'b1;
    end
  end

  assign bus.evt_valid = r_evt_valid;
  assign bus.evt_isi   = r_evt_isi;
  assign bus.evt_burst = r_evt_burst;
  assign o_spike       = r_spike;
  assign o_spike_count = r_spike_count;
  assign o_evt_ovf     = r_evt_ovf;
  assign o_in_burst    = r_in_burst;
  assign o_burst_done  = r_burst_done;
  assign o_burst_len   = r_burst_len;

endmodule

// File: doc/izh_spike_decoder.md
# izh_spike_decoder

Receive-side companion to the Izhikevich neuron core: consumes the neuron's 8-bit signed membrane-voltage sample stream and decodes it into discrete spike events. Per spike it produces a one-cycle pulse, a saturating spike count and a measured inter-spike interval (ISI). ISIs are classified against a burst threshold and delivered through a one-entry valid/ready event register. It sits between the neuron output bus and downstream logic (host readout, pattern classifier, or a synapse driving the next neuron's current input).

## Interface
Parameters:
- THRESH, 8'sd64: signed spike threshold; a spike is detected when v_in > THRESH while armed.
- REARM, -8'sd32: signed re-arm level; detector re-arms when v_in < REARM.
- ISI_W, 16: ISI counter/event width.
- CNT_W, 16: spike counter width.
- BURST_ISI, 8: an ISI ≤ BURST_ISI (in samples) is a burst interval; must be ≥ 1 and < 2^ISI_W−1.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  sample strobe; v_in is evaluated only on cycles with ena=1.
- v_in  in  8  signed membrane voltage sample from the neuron.
- clr_cnt  in  1  synchronous clear of spike_count and evt_ovf.
- spike  out  1  one-cycle spike pulse.
- spike_count  out  CNT_W  saturating spike count.
- evt_valid  out  1  ISI event pending.
- evt_ready  in  1  consumer accepts the event.
- evt_isi  out  ISI_W  ISI of the pending event, in samples.
- evt_burst  out  1  pending event's ISI ≤ BURST_ISI.
- evt_ovf  out  1  sticky: an event was dropped.
- in_burst  out  1  current spike run has ≥ 2 spikes.
- burst_done  out  1  one-cycle pulse at burst termination.
- burst_len  out  8  spike count of the last completed burst (saturates at 255).

## Operation
- Detector FSM with two states. ARMED (reset state): on an ena sample with v_in > THRESH (signed compare), fire a spike and go to FIRED. FIRED: on an ena sample with v_in < REARM, go to ARMED; no spikes are fired while in FIRED.
- isi_cnt, ISI_W bits, reset 0. On each ena sample: spike → isi_cnt <= 1; otherwise isi_cnt <= isi_cnt+1, saturating at all-ones.
- On a spike sample, the captured ISI is the old isi_cnt value, i.e. the sample distance from the previous spike sample.
- have_prev flag, reset 0. The first spike after reset produces no ISI event and then sets have_prev. clr_cnt does not clear have_prev.
- Event register:
  - Spike with have_prev=1 creates an event {ISI, ISI ≤ BURST_ISI}.
  - Register empty, or evt_ready=1 in the same cycle: load the event, evt_valid=1.
  - Register full and evt_ready=0: drop the new event, set evt_ovf.
  - evt_valid & evt_ready with no new event: clear evt_valid.
  - evt_isi and evt_burst stay stable while evt_valid=1.
- Burst run counter run (8 bits, saturating, reset 0):
  - Spike with have_prev and ISI ≤ BURST_ISI: run <= run+1.
  - Any other spike: if run ≥ 2, pulse burst_done and burst_len <= run; then run <= 1.
  - Timeout: on a non-spike ena sample with old isi_cnt == BURST_ISI and run ≥ 2, pulse burst_done, burst_len <= run, run <= 1.
  - in_burst = (run ≥ 2).
- spike_count increments on each spike and saturates at all-ones. clr_cnt zeroes it and has priority over a same-cycle increment. All other spike effects still occur on that cycle.
- ena=0: detector, isi_cnt, run and counts are frozen; no spike or burst_done pulses. The event handshake still operates.

## Timing
- All outputs are registered. spike, evt_valid load, burst_done and count updates appear on the cycle after the clock edge that sampled the triggering v_in with ena=1 (1-cycle latency).
- spike and burst_done are exactly one cycle wide.
- Reset values: state ARMED, isi_cnt=0, have_prev=0, run=0; every output 0. rst mid-operation discards any pending event and any in-progress burst with no burst_done.
- rst overrides all other inputs, including clr_cnt and evt_ready.

## Test plan
- Reset: hold rst 2 cycles with v_in=70, ena=1 → every output 0; no spike until rst falls.
- First spike: ena=1, v_in −60,10,70,−39 → single spike after the 70 sample, spike_count=1, evt_valid stays 0.
- Periodic: with evt_ready=1, a 70 sample every 20 samples (−39 otherwise) → from the 2nd spike on, evt_isi=20, evt_burst=0, in_burst=0.
- Burst: three spikes 5 samples apart, then −39 → evt_isi=5 with evt_burst=1 twice; in_burst rises with the 2nd spike; burst_done with burst_len=3 after the 8th sample following the last spike, in_burst then 0.
- Backpressure: evt_ready=0, spikes at ISI 20 then 30 → evt_isi holds 20 and evt_ovf=1. A one-cycle evt_ready pulse drops evt_valid. clr_cnt → spike_count=0, evt_ovf=0.
- Hysteresis: v_in 70,70,0,70 → one spike only; v_in 70,−40,70 → two spikes with ISI 2. ena=0 cycles inserted between samples leave results unchanged.
